// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the byte-stream command decoder:
//   - command address/data widths
//   - default frame start marker
//   - decoder FSM state encoding
//   - running checksum helper (8-bit two's-complement sum)
// -----------------------------------------------------------------------------
package cmd_pkg;

  localparam int unsigned CMD_ADDR_WIDTH = 16;
  localparam int unsigned CMD_DATA_WIDTH = 32;
  localparam logic [7:0]  CMD_SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    ISSUE = 3'd4
  } cmd_state_t;

  // Adding every payload byte plus the checksum byte must give zero mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// -----------------------------------------------------------------------------
// cmd_timeout_counter
// Inter-byte idle counter. Counts clocks while enabled, clears on request, and
// raises o_expired once the count reaches TIMEOUT_CYCLES (the count then holds
// there until cleared). TIMEOUT_CYCLES = 0 removes the counter entirely and
// o_expired is tied low.
//
// Ports:
//   clk_i      clock (rising edge)
//   rst_i      synchronous active-high reset
//   i_clr      clear the count (takes priority over counting)
//   i_en       count this cycle
//   o_expired  count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module cmd_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused  = ^{clk_i, rst_i, i_clr, i_en};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i || i_clr) begin
          r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_expired = (r_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/cmd_byte_decoder.sv
// -----------------------------------------------------------------------------
// cmd_byte_decoder
// Turns a framed host byte stream into single-cycle command writes.
//
// Frame (big-endian fields):
//   SYNC, ADDR[15:8], ADDR[7:0], DATA[31:24], DATA[23:16], DATA[15:8],
//   DATA[7:0], CSUM
// CSUM makes the 8-bit sum of the six payload bytes plus CSUM zero.
//
// Build option: CMD_BYTE_DECODER_CHECKSUM_EN
//   defined   - 8-byte frames, CSUM byte checked, bad frames counted as errors
//   undefined - 7-byte frames, last DATA byte goes straight to the write
//
// Ports:
//   clk_i          clock (rising edge)
//   rst_i          synchronous active-high reset
//   byte_data_i    incoming byte
//   byte_valid_i   byte_data_i is valid
//   byte_ready_o   decoder accepts a byte this cycle (low in ISSUE and reset)
//   cmd_addr_o     last issued write address (registered)
//   cmd_data_o     last issued write data (registered)
//   cmd_valid_o    one-cycle write strobe (registered)
//   frame_count_o  good frames issued, wraps
//   err_count_o    rejected frames (checksum/timeout), saturates at 8'hFF
//
// ADDR_WIDTH must stay 16 and DATA_WIDTH 32: the byte assembly assumes 2 and 4
// bytes respectively.
// -----------------------------------------------------------------------------
module cmd_byte_decoder
  import cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = CMD_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = CMD_DATA_WIDTH,
  parameter logic [7:0]  SYNC_BYTE      = CMD_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  output logic                  cmd_valid_o,
  output logic [15:0]           frame_count_o,
  output logic [7:0]            err_count_o
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  cmd_state_t            r_state;
  logic [1:0]            r_idx;
  logic [ADDR_WIDTH-1:0] r_addr_sh;
  logic [DATA_WIDTH-1:0] r_data_sh;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_data;
  logic                  r_cmd_valid;
  logic [15:0]           r_frame_cnt;
  logic [7:0]            r_err_cnt;
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic w_ready;
  logic w_accept;
  logic w_in_frame;
  logic w_to_expired;
  logic w_timeout;

  assign w_ready    = !rst_i && (r_state != ISSUE);
  assign w_accept   = byte_valid_i && w_ready;
  assign w_in_frame = (r_state == ADDR) || (r_state == DATA) || (r_state == CSUM);
  // A byte arriving in the expiry cycle still counts as on time.
  assign w_timeout  = w_to_expired && w_in_frame && !w_accept;

  // Counter is held clear outside a frame, so entering IDLE always clears it.
  cmd_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clr     (w_accept || !w_in_frame),
    .i_en      (w_in_frame),
    .o_expired (w_to_expired)
  );

  // Control: FSM, output registers and status counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_timeout) begin
        r_state   <= IDLE;
        r_err_cnt <= sat_inc8(r_err_cnt);
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept && (byte_data_i == SYNC_BYTE)) begin
              r_state <= ADDR;
              r_idx   <= 2'd0;
            end
          end
          ADDR: begin
            if (w_accept) begin
              if (r_idx == 2'd1) begin
                r_state <= DATA;
                r_idx   <= 2'd0;
              end else begin
                r_idx <= r_idx + 2'd1;
              end
            end
          end
          DATA: begin
            if (w_accept) begin
              r_idx <= r_idx + 2'd1;
              if (r_idx == 2'd3) begin
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
                r_state <= CSUM;
`else
                // Last data byte is taken from the input directly so the
                // write lands in the very next cycle.
                r_state     <= ISSUE;
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= r_addr_sh;
                r_cmd_data  <= {r_data_sh[DATA_WIDTH-9:0], byte_data_i};
                r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
              end
            end
          end
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
          CSUM: begin
            if (w_accept) begin
              if (csum_add(r_sum, byte_data_i) == 8'd0) begin
                r_state     <= ISSUE;
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= r_addr_sh;
                r_cmd_data  <= r_data_sh;
                r_frame_cnt <= r_frame_cnt + 16'd1;
              end else begin
                r_state   <= IDLE;
                r_err_cnt <= sat_inc8(r_err_cnt);
              end
            end
          end
`endif
          ISSUE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Datapath: byte assembly shift registers and running checksum
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      case (r_state)
        IDLE: begin
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
          r_sum <= 8'd0;
`endif
        end
        ADDR: begin
          r_addr_sh <= {r_addr_sh[ADDR_WIDTH-9:0], byte_data_i};
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
          r_sum <= csum_add(r_sum, byte_data_i);
`endif
        end
        DATA: begin
          r_data_sh <= {r_data_sh[DATA_WIDTH-9:0], byte_data_i};
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
          r_sum <= csum_add(r_sum, byte_data_i);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign byte_ready_o  = w_ready;
  assign cmd_addr_o    = r_cmd_addr;
  assign cmd_data_o    = r_cmd_data;
  assign cmd_valid_o   = r_cmd_valid;
  assign frame_count_o = r_frame_cnt;
  assign err_count_o   = r_err_cnt;

endmodule

// File: tb/tb_cmd_byte_decoder.sv
// -----------------------------------------------------------------------------
// tb_cmd_byte_decoder
// Directed bench for cmd_byte_decoder with TIMEOUT_CYCLES = 16. Frame bytes and
// checksums are hand-computed constants; expectations depend on whether
// CMD_BYTE_DECODER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_cmd_byte_decoder;

`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif

  // Hand-built frames: SYNC, ADDR(2), DATA(4), CSUM
  localparam logic [63:0] F_A0     = 64'hA5_00A0_00003C00_24;
  localparam logic [63:0] F_A0_BAD = 64'hA5_00A0_00003C00_25;
  localparam logic [63:0] F_10     = 64'hA5_0010_00000100_EF;
  localparam logic [63:0] F_28     = 64'hA5_0028_00000001_D7;
  localparam logic [63:0] F_SYNC   = 64'hA5_00A5_A5A5A5A5_C7;

  logic        clk;
  logic        rst_i;
  logic [7:0]  byte_data_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [15:0] cmd_addr_o;
  logic [31:0] cmd_data_o;
  logic        cmd_valid_o;
  logic [15:0] frame_count_o;
  logic [7:0]  err_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_pulse = 0;
  int pulse_cyc = 0;
  int prev_pulse_cyc = 0;

  int exp_fc;
  int exp_ec;
  int exp_pulses;
  int p0;

  cmd_byte_decoder #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .byte_data_i   (byte_data_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .cmd_addr_o    (cmd_addr_o),
    .cmd_data_o    (cmd_data_o),
    .cmd_valid_o   (cmd_valid_o),
    .frame_count_o (frame_count_o),
    .err_count_o   (err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count strobe cycles and remember when the last two happened
  always @(negedge clk) begin
    if (cmd_valid_o) begin
      n_pulse        <= n_pulse + 1;
      prev_pulse_cyc <= pulse_cyc;
      pulse_cyc      <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    byte_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    byte_data_i  = b;
    byte_valid_i = 1'b1;
    guard = 0;
    while (!byte_ready_o && guard < 16) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 16) check_eq("ready_wait", 32'(byte_ready_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < FRAME_LEN; i++) send_byte(f[63-8*i -: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_i        = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(byte_ready_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 32'(byte_ready_o), 32'd1);
    check_eq("post_rst_valid", 32'(cmd_valid_o), 32'd0);
    check_eq("post_rst_addr", 32'(cmd_addr_o), 32'd0);
    check_eq("post_rst_data", cmd_data_o, 32'd0);
    check_eq("post_rst_fc", 32'(frame_count_o), 32'd0);
    check_eq("post_rst_ec", 32'(err_count_o), 32'd0);

    // Good frame: strobe in the cycle after the last byte
    send_frame(F_A0);
    check_eq("t1_valid_n1", 32'(cmd_valid_o), 32'd1);
    check_eq("t1_ready_issue", 32'(byte_ready_o), 32'd0);
    check_eq("t1_fc", 32'(frame_count_o), 32'd1);
    check_eq("t1_addr", 32'(cmd_addr_o), 32'h00A0);
    check_eq("t1_data", cmd_data_o, 32'h00003C00);
    idle(3);
    check_eq("t1_valid_off", 32'(cmd_valid_o), 32'd0);
    check_eq("t1_pulses", 32'(n_pulse), 32'd1);
    check_eq("t1_ec", 32'(err_count_o), 32'd0);
    exp_fc = 1; exp_ec = 0; exp_pulses = 1;

    // Bad checksum, then a good frame
    send_frame(F_A0_BAD);
    idle(3);
`ifdef CMD_BYTE_DECODER_CHECKSUM_EN
    exp_ec = exp_ec + 1;
`else
    exp_fc = exp_fc + 1;
    exp_pulses = exp_pulses + 1;
`endif
    check_eq("t2_ec", 32'(err_count_o), 32'(exp_ec));
    check_eq("t2_fc", 32'(frame_count_o), 32'(exp_fc));
    check_eq("t2_pulses", 32'(n_pulse), 32'(exp_pulses));
    check_eq("t2_addr_hold", 32'(cmd_addr_o), 32'h00A0);
    send_frame(F_10);
    idle(3);
    exp_fc = exp_fc + 1; exp_pulses = exp_pulses + 1;
    check_eq("t2b_addr", 32'(cmd_addr_o), 32'h0010);
    check_eq("t2b_data", cmd_data_o, 32'h00000100);
    check_eq("t2b_fc", 32'(frame_count_o), 32'(exp_fc));

    // Junk before SYNC is discarded silently
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'hFF);
    send_frame(F_A0);
    idle(3);
    exp_fc = exp_fc + 1; exp_pulses = exp_pulses + 1;
    check_eq("t3_pulses", 32'(n_pulse), 32'(exp_pulses));
    check_eq("t3_addr", 32'(cmd_addr_o), 32'h00A0);
    check_eq("t3_data", cmd_data_o, 32'h00003C00);
    check_eq("t3_ec", 32'(err_count_o), 32'(exp_ec));

    // SYNC value inside the payload is ordinary data
    send_frame(F_SYNC);
    idle(3);
    exp_fc = exp_fc + 1; exp_pulses = exp_pulses + 1;
    check_eq("t4_addr", 32'(cmd_addr_o), 32'h00A5);
    check_eq("t4_data", cmd_data_o, 32'hA5A5A5A5);
    check_eq("t4_fc", 32'(frame_count_o), 32'(exp_fc));

    // Timeout mid-frame
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(20);
    exp_ec = exp_ec + 1;
    check_eq("t5_ec", 32'(err_count_o), 32'(exp_ec));
    check_eq("t5_pulses", 32'(n_pulse), 32'(exp_pulses));
    check_eq("t5_addr_hold", 32'(cmd_addr_o), 32'h00A5);
    send_frame(F_28);
    idle(3);
    exp_fc = exp_fc + 1; exp_pulses = exp_pulses + 1;
    check_eq("t5b_addr", 32'(cmd_addr_o), 32'h0028);
    check_eq("t5b_data", cmd_data_o, 32'h00000001);
    check_eq("t5b_fc", 32'(frame_count_o), 32'(exp_fc));

    // Reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hA0);
    send_byte(8'h00);
    byte_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_rst_ready", 32'(byte_ready_o), 32'd0);
    check_eq("t6_rst_valid", 32'(cmd_valid_o), 32'd0);
    check_eq("t6_rst_addr", 32'(cmd_addr_o), 32'd0);
    check_eq("t6_rst_data", cmd_data_o, 32'd0);
    check_eq("t6_rst_fc", 32'(frame_count_o), 32'd0);
    check_eq("t6_rst_ec", 32'(err_count_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_ready", 32'(byte_ready_o), 32'd1);
    send_byte(8'h00);
    send_byte(8'h3C);
    send_byte(8'h00);
    send_byte(8'h24);
    idle(3);
    check_eq("t6_pulses", 32'(n_pulse), 32'(exp_pulses));
    check_eq("t6_fc", 32'(frame_count_o), 32'd0);
    check_eq("t6_addr", 32'(cmd_addr_o), 32'd0);

    // Back-to-back frames
    p0 = n_pulse;
    send_frame(F_10);
    check_eq("t7_ready_issue1", 32'(byte_ready_o), 32'd0);
    send_frame(F_28);
    check_eq("t7_ready_issue2", 32'(byte_ready_o), 32'd0);
    idle(3);
    check_eq("t7_pulses", 32'(n_pulse - p0), 32'd2);
    check_eq("t7_gap", 32'(pulse_cyc - prev_pulse_cyc), 32'(FRAME_LEN + 1));
    check_eq("t7_fc", 32'(frame_count_o), 32'd2);
    check_eq("t7_addr", 32'(cmd_addr_o), 32'h0028);
    check_eq("t7_data", cmd_data_o, 32'h00000001);
    check_eq("t7_ec", 32'(err_count_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
